// File: rtl/score_overlay_ctrl.sv
// Score-panel overlay sequencer: window ROM addressing, frame-locked level-up
// blink/hold sequence, and pixel-valid/image-select aligned with ROM read data.
module score_overlay_ctrl #(
  parameter int WIN_X0       = 40,
  parameter int WIN_Y0       = 210,
  parameter int WIN_W        = 240,
  parameter int WIN_H        = 120,
  parameter int BLINK_FRAMES = 15,
  parameter int BLINK_COUNT  = 4,
  parameter int HOLD_FRAMES  = 60,
  parameter int ADDR_W       = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       col_addr_sig,
  input  logic [10:0]       row_addr_sig,
  input  logic              frame_start,
  input  logic              levelup_sig,
  input  logic              game_over,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_sel,
  output logic              pix_valid,
  output logic [3:0]        level,
  output logic              busy
);

  localparam int FMAX = (BLINK_FRAMES > HOLD_FRAMES) ? BLINK_FRAMES : HOLD_FRAMES;
  localparam int FCW  = (FMAX > 1) ? $clog2(FMAX) : 1;
  localparam int BCW  = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

  typedef enum logic [2:0] {
    NORMAL    = 3'd0,
    BLINK_ON  = 3'd1,
    BLINK_OFF = 3'd2,
    HOLD      = 3'd3,
    FROZEN    = 3'd4
  } state_t;

  state_t         state_r, state_s;
  logic [FCW-1:0] frame_cnt_r, frame_cnt_s;
  logic [BCW-1:0] blink_cnt_r, blink_cnt_s;
  logic           pending_r;
  logic           consume_s;
  logic           busy_s;

  logic           in_win_s;
  logic [10:0]    col_off_s, row_off_s;
  logic [21:0]    addr_full_s;
  logic           valid_d1_r, sel_d1_r;
  logic           valid_s, sel_s;

  // Window test and linear ROM address for the current pixel
  always_comb begin
    in_win_s    = (col_addr_sig >= 11'(WIN_X0)) && (col_addr_sig < 11'(WIN_X0 + WIN_W)) &&
                  (row_addr_sig >= 11'(WIN_Y0)) && (row_addr_sig < 11'(WIN_Y0 + WIN_H));
    col_off_s   = col_addr_sig - 11'(WIN_X0);
    row_off_s   = row_addr_sig - 11'(WIN_Y0);
    addr_full_s = ({11'd0, row_off_s} * 22'(WIN_W)) + {11'd0, col_off_s};
  end

  // Overlay decode from the current state; BLINK_OFF blanks the panel
  always_comb begin
    valid_s = in_win_s && (state_r != BLINK_OFF);
    case (state_r)
      BLINK_ON, HOLD, FROZEN: sel_s = 1'b1;
      default:                sel_s = 1'b0;
    endcase
  end

  // Next-state logic; only frame_start cycles may change the image
  always_comb begin
    state_s     = state_r;
    frame_cnt_s = frame_cnt_r;
    blink_cnt_s = blink_cnt_r;
    consume_s   = 1'b0;
    if (frame_start) begin
      if (game_over || (state_r == FROZEN)) begin
        state_s     = FROZEN;
        frame_cnt_s = '0;
        blink_cnt_s = '0;
      end else if (pending_r) begin
        state_s     = BLINK_ON;
        frame_cnt_s = '0;
        blink_cnt_s = '0;
        consume_s   = 1'b1;
      end else begin
        case (state_r)
          BLINK_ON: begin
            if (frame_cnt_r == FCW'(BLINK_FRAMES - 1)) begin
              state_s     = BLINK_OFF;
              frame_cnt_s = '0;
            end else begin
              frame_cnt_s = frame_cnt_r + 1'b1;
            end
          end
          BLINK_OFF: begin
            if (frame_cnt_r == FCW'(BLINK_FRAMES - 1)) begin
              frame_cnt_s = '0;
              if (blink_cnt_r == BCW'(BLINK_COUNT - 1)) begin
                state_s     = HOLD;
                blink_cnt_s = '0;
              end else begin
                state_s     = BLINK_ON;
                blink_cnt_s = blink_cnt_r + 1'b1;
              end
            end else begin
              frame_cnt_s = frame_cnt_r + 1'b1;
            end
          end
          HOLD: begin
            if (frame_cnt_r == FCW'(HOLD_FRAMES - 1)) begin
              state_s     = NORMAL;
              frame_cnt_s = '0;
            end else begin
              frame_cnt_s = frame_cnt_r + 1'b1;
            end
          end
          default: state_s = state_r;
        endcase
      end
    end else begin
      state_s = state_r;
    end
  end

  // Busy decode of the next state so the registered flag tracks the state
  always_comb begin
    case (state_s)
      BLINK_ON, BLINK_OFF, HOLD: busy_s = 1'b1;
      default:                   busy_s = 1'b0;
    endcase
  end

  // State, counters, pending request and level register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= NORMAL;
      frame_cnt_r <= '0;
      blink_cnt_r <= '0;
      pending_r   <= 1'b0;
      level       <= 4'd0;
      busy        <= 1'b0;
    end else begin
      state_r     <= state_s;
      frame_cnt_r <= frame_cnt_s;
      blink_cnt_r <= blink_cnt_s;
      busy        <= busy_s;
      // A new request wins over consumption so a same-cycle pulse waits a frame
      if (levelup_sig) begin
        pending_r <= 1'b1;
      end else if (consume_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
      if (levelup_sig && (level != 4'd15)) begin
        level <= level + 4'd1;
      end else begin
        level <= level;
      end
    end
  end

  // Address register and two-stage alignment of valid/select with ROM data
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr   <= '0;
      valid_d1_r <= 1'b0;
      sel_d1_r   <= 1'b0;
      pix_valid  <= 1'b0;
      rom_sel    <= 1'b0;
    end else begin
      rom_addr   <= in_win_s ? addr_full_s[ADDR_W-1:0] : '0;
      valid_d1_r <= valid_s;
      sel_d1_r   <= sel_s;
      pix_valid  <= valid_d1_r;
      rom_sel    <= sel_d1_r;
    end
  end

endmodule
